// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
// Round-robin arbiter sharing one Wishbone slave port between three j1 CPU masters.
// A master keeps the grant for its whole cyc cycle, bursts included. Data and ack
// are returned only to the current owner.
//
// Optional feature: define WB_ARB_WATCHDOG_EN to build in a watchdog. It aborts an
// owner whose slave never acknowledges within TMO cycles, by pulsing that master's
// err line and dropping the bus.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   wb_ack, wb_dat_o           slave acknowledge and read data (inputs)
//   wb_cyc, wb_stb, wb_we      bus controls to slave
//   wb_adr, wb_dat_i           address / write data to slave
//   cpuN_cyc_o, cpuN_we_o      master N request / write enable (inputs)
//   cpuN_adr_o, cpuN_dat_o     master N address / write data (inputs)
//   cpuN_dat_i, cpuN_ack_i     read data / ack returned to master N
//   cpuN_err_i                 watchdog abort to master N (0 without watchdog)
//   gnt                        registered one-hot current owner
module wb_rr_arbiter #(
   parameter int unsigned DW  = 32,
   parameter int unsigned TMO = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_ack,
   input  logic [DW-1:0] wb_dat_o,
   output logic          wb_cyc,
   output logic          wb_stb,
   output logic          wb_we,
   output logic [DW-1:0] wb_adr,
   output logic [DW-1:0] wb_dat_i,
   input  logic          cpu0_cyc_o,
   input  logic          cpu0_we_o,
   input  logic [DW-1:0] cpu0_adr_o,
   input  logic [DW-1:0] cpu0_dat_o,
   output logic [DW-1:0] cpu0_dat_i,
   output logic          cpu0_ack_i,
   output logic          cpu0_err_i,
   input  logic          cpu1_cyc_o,
   input  logic          cpu1_we_o,
   input  logic [DW-1:0] cpu1_adr_o,
   input  logic [DW-1:0] cpu1_dat_o,
   output logic [DW-1:0] cpu1_dat_i,
   output logic          cpu1_ack_i,
   output logic          cpu1_err_i,
   input  logic          cpu2_cyc_o,
   input  logic          cpu2_we_o,
   input  logic [DW-1:0] cpu2_adr_o,
   input  logic [DW-1:0] cpu2_dat_o,
   output logic [DW-1:0] cpu2_dat_i,
   output logic          cpu2_ack_i,
   output logic          cpu2_err_i,
   output logic [2:0]    gnt
);

   typedef enum logic [1:0] {StIdle, StOwn, StDrop} state_e;

   state_e      state_q, state_d;
   logic [2:0]  gnt_q, gnt_d;
   // Index of the last / current owner; 2 after reset so cpu0 is searched first.
   logic [1:0]  ptr_q, ptr_d;

   logic [2:0]  req;
   logic        in_own;
   logic        own_cyc;
   logic        own_we;
   logic [DW-1:0] own_adr;
   logic [DW-1:0] own_dat;
   logic [1:0]  winner;
   logic        wd_fire;
   logic [2:0]  err;

   assign req    = {cpu2_cyc_o, cpu1_cyc_o, cpu0_cyc_o};
   assign in_own = (state_q == StOwn);

   // First requester searching upward (mod 3) from ptr+1; the last owner comes last.
   function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
      logic [1:0] i1;
      logic [1:0] i2;
      i1 = (p == 2'd2) ? 2'd0 : p + 2'd1;
      i2 = (i1 == 2'd2) ? 2'd0 : i1 + 2'd1;
      if (r[i1]) begin
         rr_pick = i1;
      end else if (r[i2]) begin
         rr_pick = i2;
      end else begin
         rr_pick = p;
      end
   endfunction

   assign winner = rr_pick(req, ptr_q);

   // Owner select; ptr_q always names the owner while in StOwn.
   always_comb begin
      own_cyc = 1'b0;
      own_we  = 1'b0;
      own_adr = '0;
      own_dat = '0;
      case (ptr_q)
         2'd0: begin
            own_cyc = cpu0_cyc_o;
            own_we  = cpu0_we_o;
            own_adr = cpu0_adr_o;
            own_dat = cpu0_dat_o;
         end
         2'd1: begin
            own_cyc = cpu1_cyc_o;
            own_we  = cpu1_we_o;
            own_adr = cpu1_adr_o;
            own_dat = cpu1_dat_o;
         end
         2'd2: begin
            own_cyc = cpu2_cyc_o;
            own_we  = cpu2_we_o;
            own_adr = cpu2_adr_o;
            own_dat = cpu2_dat_o;
         end
         default: ;
      endcase
   end

`ifdef WB_ARB_WATCHDOG_EN
   localparam int unsigned CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Limit reached while the owner still waits; a same-cycle ack wins over err.
   assign wd_fire = in_own && own_cyc && !wb_ack && (cnt_q == CW'(TMO));
`else
   logic unused_tmo;

   assign unused_tmo = ^TMO;
   assign wd_fire    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
`ifdef WB_ARB_WATCHDOG_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (|req) begin
               state_d = StOwn;
               ptr_d   = winner;
               gnt_d   = 3'b001 << winner;
`ifdef WB_ARB_WATCHDOG_EN
               cnt_d   = '0;
`endif
            end
         end
         StOwn: begin
            if (!own_cyc) begin
               state_d = StIdle;
               gnt_d   = '0;
            end
`ifdef WB_ARB_WATCHDOG_EN
            else if (wb_ack) begin
               cnt_d = '0;
            end else if (wd_fire) begin
               state_d = StDrop;
               gnt_d   = '0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         StDrop: begin
            // ptr stays on the aborted master so the others are searched first.
            if (!own_cyc) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         ptr_q   <= 2'd2;
`ifdef WB_ARB_WATCHDOG_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
`ifdef WB_ARB_WATCHDOG_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Bus side: everything zero outside StOwn, so StDrop also forces wb_cyc low.
   assign wb_cyc   = in_own & own_cyc;
   assign wb_stb   = in_own & own_cyc;
   assign wb_we    = in_own & own_we;
   assign wb_adr   = in_own ? own_adr : '0;
   assign wb_dat_i = in_own ? own_dat : '0;
   assign gnt      = gnt_q;

   // Return path: gnt_q is zero in StIdle/StDrop, so stray acks are dropped there.
   assign cpu0_dat_i = gnt_q[0] ? wb_dat_o : '0;
   assign cpu1_dat_i = gnt_q[1] ? wb_dat_o : '0;
   assign cpu2_dat_i = gnt_q[2] ? wb_dat_o : '0;
   assign cpu0_ack_i = wb_ack & gnt_q[0];
   assign cpu1_ack_i = wb_ack & gnt_q[1];
   assign cpu2_ack_i = wb_ack & gnt_q[2];

   assign err        = gnt_q & {3{wd_fire}};
   assign cpu0_err_i = err[0];
   assign cpu1_err_i = err[1];
   assign cpu2_err_i = err[2];

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed testbench for wb_rr_arbiter. Inputs change 1 time unit after the rising
// edge and outputs are sampled 1 unit later, clear of the active edge.
module tb_wb_rr_arbiter;

   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_ack;
   logic [DW-1:0] wb_dat_o;
   logic          wb_cyc, wb_stb, wb_we;
   logic [DW-1:0] wb_adr, wb_dat_i;
   logic          cpu0_cyc_o, cpu0_we_o, cpu1_cyc_o, cpu1_we_o, cpu2_cyc_o, cpu2_we_o;
   logic [DW-1:0] cpu0_adr_o, cpu0_dat_o, cpu1_adr_o, cpu1_dat_o, cpu2_adr_o, cpu2_dat_o;
   logic [DW-1:0] cpu0_dat_i, cpu1_dat_i, cpu2_dat_i;
   logic          cpu0_ack_i, cpu1_ack_i, cpu2_ack_i;
   logic          cpu0_err_i, cpu1_err_i, cpu2_err_i;
   logic [2:0]    gnt;

   int checks = 0;
   int errors = 0;

   wb_rr_arbiter #(.DW(DW), .TMO(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_ack     (wb_ack),
      .wb_dat_o   (wb_dat_o),
      .wb_cyc     (wb_cyc),
      .wb_stb     (wb_stb),
      .wb_we      (wb_we),
      .wb_adr     (wb_adr),
      .wb_dat_i   (wb_dat_i),
      .cpu0_cyc_o (cpu0_cyc_o),
      .cpu0_we_o  (cpu0_we_o),
      .cpu0_adr_o (cpu0_adr_o),
      .cpu0_dat_o (cpu0_dat_o),
      .cpu0_dat_i (cpu0_dat_i),
      .cpu0_ack_i (cpu0_ack_i),
      .cpu0_err_i (cpu0_err_i),
      .cpu1_cyc_o (cpu1_cyc_o),
      .cpu1_we_o  (cpu1_we_o),
      .cpu1_adr_o (cpu1_adr_o),
      .cpu1_dat_o (cpu1_dat_o),
      .cpu1_dat_i (cpu1_dat_i),
      .cpu1_ack_i (cpu1_ack_i),
      .cpu1_err_i (cpu1_err_i),
      .cpu2_cyc_o (cpu2_cyc_o),
      .cpu2_we_o  (cpu2_we_o),
      .cpu2_adr_o (cpu2_adr_o),
      .cpu2_dat_o (cpu2_dat_o),
      .cpu2_dat_i (cpu2_dat_i),
      .cpu2_ack_i (cpu2_ack_i),
      .cpu2_err_i (cpu2_err_i),
      .gnt        (gnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Owner granted, gets one ack, releases; checks grant, address, dead cycle.
   task automatic serve(input string tag, input logic [2:0] exp_gnt, input logic [31:0] exp_adr);
      check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
      check({tag, "_adr"}, wb_adr, exp_adr);
      wb_ack   = 1'b1;
      wb_dat_o = exp_adr + 32'h5;
      settle();
      check({tag, "_acks"}, 32'({cpu2_ack_i, cpu1_ack_i, cpu0_ack_i}), 32'(exp_gnt));
      tick();
      wb_ack = 1'b0;
      if (exp_gnt[0]) cpu0_cyc_o = 1'b0;
      if (exp_gnt[1]) cpu1_cyc_o = 1'b0;
      if (exp_gnt[2]) cpu2_cyc_o = 1'b0;
      settle();
      check({tag, "_rel_cyc"}, 32'(wb_cyc), 32'd0);
      tick();
      check({tag, "_dead_gnt"}, 32'(gnt), 32'd0);
      tick();
   endtask

   initial begin
      rst = 1'b1; wb_ack = 1'b0; wb_dat_o = '0;
      cpu0_cyc_o = 0; cpu0_we_o = 0; cpu0_adr_o = '0; cpu0_dat_o = '0;
      cpu1_cyc_o = 0; cpu1_we_o = 0; cpu1_adr_o = '0; cpu1_dat_o = '0;
      cpu2_cyc_o = 0; cpu2_we_o = 0; cpu2_adr_o = '0; cpu2_dat_o = '0;
      tick(); tick();
      rst = 1'b0;
      settle();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_cyc", 32'(wb_cyc), 32'd0);
      check("rst_adr", wb_adr, 32'd0);
      check("rst_acks", 32'({cpu2_ack_i, cpu1_ack_i, cpu0_ack_i}), 32'd0);
      check("rst_errs", 32'({cpu2_err_i, cpu1_err_i, cpu0_err_i}), 32'd0);

      // cpu1 alone, read acked 3 cycles after wb_cyc rises.
      tick();
      cpu1_cyc_o = 1'b1; cpu1_adr_o = 32'h40;
      settle();
      check("t1_no_gnt_yet", 32'(gnt), 32'd0);
      check("t1_no_cyc_yet", 32'(wb_cyc), 32'd0);
      tick();
      check("t1_gnt", 32'(gnt), 32'b010);
      check("t1_cyc", 32'(wb_cyc), 32'd1);
      check("t1_adr", wb_adr, 32'h40);
      tick(); tick(); tick();
      wb_ack = 1'b1; wb_dat_o = 32'h12345678;
      settle();
      check("t1_ack1", 32'(cpu1_ack_i), 32'd1);
      check("t1_dat1", cpu1_dat_i, 32'h12345678);
      check("t1_ack0", 32'(cpu0_ack_i), 32'd0);
      check("t1_ack2", 32'(cpu2_ack_i), 32'd0);
      check("t1_dat0", cpu0_dat_i, 32'd0);
      tick();
      wb_ack = 1'b0; cpu1_cyc_o = 1'b0;
      settle();
      check("t1_ack1_off", 32'(cpu1_ack_i), 32'd0);
      check("t1_cyc_fall", 32'(wb_cyc), 32'd0);
      tick();
      check("t1_idle", 32'(gnt), 32'd0);

      // All three from reset: order cpu0, cpu1, cpu2.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cpu0_cyc_o = 1; cpu0_adr_o = 32'h100;
      cpu1_cyc_o = 1; cpu1_adr_o = 32'h200;
      cpu2_cyc_o = 1; cpu2_adr_o = 32'h300;
      tick();
      serve("t2_cpu0", 3'b001, 32'h100);
      serve("t2_cpu1", 3'b010, 32'h200);
      serve("t2_cpu2", 3'b100, 32'h300);
      check("t2_idle", 32'(gnt), 32'd0);

      // cpu0 4-ack burst while cpu2 waits.
      cpu0_cyc_o = 1; cpu0_adr_o = 32'h500;
      tick();
      check("t3_gnt0", 32'(gnt), 32'b001);
      cpu2_cyc_o = 1; cpu2_adr_o = 32'h600;
      for (int i = 0; i < 4; i++) begin
         wb_ack = 1'b1;
         settle();
         check("t3_burst_ack0", 32'(cpu0_ack_i), 32'd1);
         check("t3_burst_ack2", 32'(cpu2_ack_i), 32'd0);
         check("t3_burst_gnt", 32'(gnt), 32'b001);
         tick();
      end
      wb_ack = 1'b0; cpu0_cyc_o = 1'b0;
      settle();
      check("t3_rel_gnt", 32'(gnt), 32'b001);
      tick();
      check("t3_dead", 32'(gnt), 32'd0);
      tick();
      check("t3_gnt2", 32'(gnt), 32'b100);
      check("t3_adr2", wb_adr, 32'h600);
      cpu2_cyc_o = 1'b0;
      tick(); tick();

      // cpu0 re-requests right after release; waiting cpu1 goes first.
      cpu0_cyc_o = 1; cpu0_adr_o = 32'h110;
      tick();
      check("t4_gnt0", 32'(gnt), 32'b001);
      cpu1_cyc_o = 1; cpu1_adr_o = 32'h210;
      tick();
      cpu0_cyc_o = 1'b0;
      tick();
      cpu0_cyc_o = 1'b1;
      settle();
      check("t4_dead", 32'(gnt), 32'd0);
      tick();
      check("t4_gnt1", 32'(gnt), 32'b010);
      check("t4_adr1", wb_adr, 32'h210);
      cpu1_cyc_o = 1'b0;
      tick(); tick();
      check("t4_gnt0_again", 32'(gnt), 32'b001);
      cpu0_cyc_o = 1'b0;
      tick(); tick();

      // Reset mid-write while cpu2 owns; abandoned ack not forwarded.
      cpu2_cyc_o = 1; cpu2_we_o = 1; cpu2_adr_o = 32'h700; cpu2_dat_o = 32'hDEAD;
      tick();
      check("t5_gnt2", 32'(gnt), 32'b100);
      check("t5_we", 32'(wb_we), 32'd1);
      check("t5_wdat", wb_dat_i, 32'hDEAD);
      rst = 1'b1;
      tick();
      rst = 1'b0; wb_ack = 1'b1; cpu0_cyc_o = 1; cpu0_adr_o = 32'h800;
      settle();
      check("t5_rst_gnt", 32'(gnt), 32'd0);
      check("t5_rst_cyc", 32'(wb_cyc), 32'd0);
      check("t5_rst_ack2", 32'(cpu2_ack_i), 32'd0);
      wb_ack = 1'b0;
      tick();
      check("t5_gnt0", 32'(gnt), 32'b001);
      check("t5_adr0", wb_adr, 32'h800);
      cpu0_cyc_o = 1'b0; cpu2_cyc_o = 1'b0; cpu2_we_o = 1'b0;
      tick(); tick();

      // Slave never acks cpu1.
      cpu1_cyc_o = 1; cpu1_adr_o = 32'h900;
      tick();
      check("t6_gnt1", 32'(gnt), 32'b010);
      cpu2_cyc_o = 1; cpu2_adr_o = 32'hA00;
`ifdef WB_ARB_WATCHDOG_EN
      for (int i = 0; i < 8; i++) begin
         settle();
         check("t6_err_early", 32'(cpu1_err_i), 32'd0);
         check("t6_cyc_held", 32'(wb_cyc), 32'd1);
         tick();
      end
      settle();
      check("t6_err_pulse", 32'(cpu1_err_i), 32'd1);
      check("t6_ack_off", 32'(cpu1_ack_i), 32'd0);
      check("t6_other_err", 32'({cpu2_err_i, cpu0_err_i}), 32'd0);
      tick();
      check("t6_err_done", 32'(cpu1_err_i), 32'd0);
      check("t6_drop_cyc", 32'(wb_cyc), 32'd0);
      check("t6_drop_gnt", 32'(gnt), 32'd0);
      tick();
      check("t6_drop_hold", 32'(gnt), 32'd0);
      cpu1_cyc_o = 1'b0;
      tick();
      check("t6_idle", 32'(gnt), 32'd0);
      tick();
      check("t6_gnt2", 32'(gnt), 32'b100);
      check("t6_adr2", wb_adr, 32'hA00);
`else
      for (int i = 0; i < 12; i++) begin
         tick();
      end
      check("t6_hung_gnt", 32'(gnt), 32'b010);
      check("t6_hung_cyc", 32'(wb_cyc), 32'd1);
      check("t6_no_err", 32'({cpu2_err_i, cpu1_err_i, cpu0_err_i}), 32'd0);
      cpu1_cyc_o = 1'b0;
      tick(); tick();
      check("t6_gnt2", 32'(gnt), 32'b100);
`endif
      cpu2_cyc_o = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
